// File: rtl/pipeline_sink_watchdog_pkg.sv
// pipeline_sink_watchdog_pkg: state encoding and statistics width shared by the watchdog files.
package pipeline_sink_watchdog_pkg;

   typedef enum logic [1:0] {
      CONNECTED = 2'd0,
      SUNK      = 2'd1,
      REJOIN    = 2'd2
   } state_t;

   localparam int STATS_WIDTH = 16;

endpackage

// File: rtl/pipeline_sink_watchdog_counter_binary.sv
// Counter_Binary: binary up-counter with synchronous clear and load-zero (load-zero beats increment).
module Counter_Binary #(
   parameter int WIDTH = 5
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load_zero,
   input  logic             increment,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock) begin
      if (clear || load_zero) count <= '0;
      else if (increment) count <= count + 1'b1;
   end

endmodule

// File: rtl/pipeline_sink_watchdog.sv
// pipeline_sink_watchdog: drives a Pipeline Sink's sink input from a stall timeout and explicit requests.
// Define PIPELINE_SINK_WATCHDOG_STATS_EN to count beats discarded while sunk; otherwise sunk_beats is 0.
module pipeline_sink_watchdog
   import pipeline_sink_watchdog_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int COUNT_WIDTH    = $clog2(16 + 1)
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic                   input_valid,
   input  logic                   output_ready,
   input  logic                   disconnect,
   input  logic                   reconnect,
   output logic                   sink,
   output logic                   timed_out,
   output logic [STATS_WIDTH-1:0] sunk_beats
);

   localparam bit TIMEOUT_EN = TIMEOUT_CYCLES > 0;
   localparam logic [COUNT_WIDTH-1:0] LAST_COUNT =
      COUNT_WIDTH'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

   state_t                 state, state_next;
   logic [COUNT_WIDTH-1:0] count;
   logic                   stall, expire, timed_out_next;

   assign stall  = state == CONNECTED && input_valid && !output_ready;
   assign expire = TIMEOUT_EN && stall && count == LAST_COUNT;

   // Zeroing on expiry keeps the counter from ever reaching TIMEOUT_CYCLES.
   Counter_Binary #(.WIDTH(COUNT_WIDTH)) stall_counter (
      .clock     (clock),
      .clear     (clear),
      .load_zero (!stall || expire || disconnect),
      .increment (stall && TIMEOUT_EN),
      .count     (count)
   );

   always_comb begin
      state_next     = state;
      timed_out_next = 1'b0;
      case (state)
         CONNECTED: begin
            state_next     = (disconnect || expire) ? SUNK : CONNECTED;
            timed_out_next = expire && !disconnect;
         end
         SUNK:    state_next = (reconnect && !disconnect) ? REJOIN : SUNK;
         REJOIN:  state_next = disconnect ? SUNK : (output_ready ? CONNECTED : REJOIN);
         default: state_next = CONNECTED;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state     <= CONNECTED;
         sink      <= 1'b0;
         timed_out <= 1'b0;
      end else begin
         state     <= state_next;
         sink      <= state_next != CONNECTED;
         timed_out <= timed_out_next;
      end
   end

`ifdef PIPELINE_SINK_WATCHDOG_STATS_EN
   logic [STATS_WIDTH-1:0] beats;

   always_ff @(posedge clock) begin
      if (clear) beats <= '0;
      else if (sink && input_valid && beats != '1) beats <= beats + 1'b1;
   end

   assign sunk_beats = beats;
`else
   assign sunk_beats = '0;
`endif

endmodule

// File: tb/tb_pipeline_sink_watchdog.sv
// tb_pipeline_sink_watchdog: directed plus randomized checks of the watchdog against a run-length model.
module tb_pipeline_sink_watchdog;

   localparam int TO = 4;
`ifdef PIPELINE_SINK_WATCHDOG_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        input_valid = 1'b0;
   logic        output_ready = 1'b0;
   logic        disconnect = 1'b0;
   logic        reconnect = 1'b0;
   logic        sink, timed_out;
   logic [15:0] sunk_beats;

   int checks = 0;
   int errors = 0;
   bit armed = 1'b0;

   pipeline_sink_watchdog #(.TIMEOUT_CYCLES(TO)) dut (
      .clock        (clock),
      .clear        (clear),
      .input_valid  (input_valid),
      .output_ready (output_ready),
      .disconnect   (disconnect),
      .reconnect    (reconnect),
      .sink         (sink),
      .timed_out    (timed_out),
      .sunk_beats   (sunk_beats)
   );

   always #5 clock = ~clock;

   // Model: "sunk" flag, "waiting to rejoin" flag and the length of the current stall run.
   bit m_sink, m_rejoin, m_to;
   int m_run, m_beats;

   always @(posedge clock) begin
      if (clear) begin
         m_sink = 0; m_rejoin = 0; m_to = 0; m_run = 0; m_beats = 0;
      end else begin
         m_to = 0;
         if (STATS && m_sink && input_valid && m_beats < 65535) m_beats++;
         if (!m_sink) begin
            if (disconnect) begin
               m_sink = 1; m_run = 0;
            end else if (input_valid && !output_ready) begin
               m_run++;
               if (TO != 0 && m_run == TO) begin
                  m_sink = 1; m_to = 1; m_run = 0;
               end
            end else m_run = 0;
         end else if (disconnect) m_rejoin = 0;
         else if (!m_rejoin) m_rejoin = reconnect;
         else if (output_ready) begin
            m_sink = 0; m_rejoin = 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (armed) begin
         check("model_sink", 32'(sink), 32'(m_sink));
         check("model_timed_out", 32'(timed_out), 32'(m_to));
         check("model_sunk_beats", 32'(sunk_beats), 32'(m_beats));
      end
   end

   task automatic step(input logic v, input logic r, input logic d, input logic rc, input logic cl);
      input_valid = v; output_ready = r; disconnect = d; reconnect = rc; clear = cl;
      @(posedge clock);
      #1;
   endtask

   initial begin
      step(0, 0, 0, 0, 1);
      armed = 1'b1;
      check("reset_sink", 32'(sink), 0);
      check("reset_timed_out", 32'(timed_out), 0);
      check("reset_sunk_beats", 32'(sunk_beats), 0);

      // Timeout after TO consecutive stalls, pulse lasts one cycle.
      for (int i = 0; i < TO; i++) step(1, 0, 0, 0, 0);
      check("timeout_sink", 32'(sink), 1);
      check("timeout_pulse", 32'(timed_out), 1);
      step(1, 0, 0, 0, 0);
      check("timeout_pulse_end", 32'(timed_out), 0);
      check("timeout_sink_held", 32'(sink), 1);

      // A handshake breaks the stall run.
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      check("handshake_no_timeout", 32'(sink), 0);
      step(0, 1, 0, 0, 0);

      // Rejoin waits for downstream ready.
      step(0, 0, 1, 0, 0);
      check("disconnect_sink", 32'(sink), 1);
      check("disconnect_no_pulse", 32'(timed_out), 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      check("rejoin_wait", 32'(sink), 1);
      step(0, 1, 0, 0, 0);
      check("rejoin_done", 32'(sink), 0);

      // Disconnect wins over reconnect in SUNK and in REJOIN.
      step(0, 0, 1, 0, 0);
      step(0, 1, 1, 1, 0);
      check("both_in_sunk", 32'(sink), 1);
      step(0, 0, 0, 1, 0);
      step(0, 1, 1, 1, 0);
      check("both_in_rejoin", 32'(sink), 1);
      step(0, 1, 0, 0, 0);
      check("back_in_sunk", 32'(sink), 1);
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      check("rejoin_after_both", 32'(sink), 0);

      // Seven beats while sunk.
      step(1, 0, 1, 0, 0);
      for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
      check("sunk_beats_7", 32'(sunk_beats), STATS ? 7 : 0);

      // Clear from REJOIN under stall, then timeout fires again.
      step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1);
      check("clear_sink", 32'(sink), 0);
      check("clear_beats", 32'(sunk_beats), 0);
      for (int i = 0; i < TO - 1; i++) step(1, 0, 0, 0, 0);
      check("clear_not_yet", 32'(sink), 0);
      step(1, 0, 0, 0, 0);
      check("clear_timeout_again", 32'(timed_out), 1);

`ifdef PIPELINE_SINK_WATCHDOG_STATS_EN
      step(0, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0);
      for (int i = 0; i < 70000; i++) step(1, 0, 0, 0, 0);
      check("sunk_beats_saturate", 32'(sunk_beats), 32'hFFFF);
`endif

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);

      armed = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
